// File: rtl/fft_tw_pkg.sv
// Shared constants, types and address helpers for the twiddle ROM reader.
package fft_tw_pkg;

   localparam int STAGES = 5;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;
   localparam int SEL_W  = 3;
   localparam int BFLY_W = STAGES - 1;

   // Output register plus two skid entries: reads issued but not yet consumed
   localparam logic [2:0] TW_CREDITS = 3'd3;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } tw_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
      logic [BFLY_W-1:0] bfly;
   } tw_entry_t;

   function automatic logic [ADDR_W-1:0] tw_base(input logic [SEL_W-1:0] s);
      logic [ADDR_W:0] v;
      v = (ADDR_W+1)'(1) << s;
      return ADDR_W'(v - (ADDR_W+1)'(1));
   endfunction

   function automatic logic [BFLY_W-1:0] tw_mask(input logic [SEL_W-1:0] s);
      logic [BFLY_W:0] v;
      v = (BFLY_W+1)'(1) << s;
      return BFLY_W'(v - (BFLY_W+1)'(1));
   endfunction

   function automatic logic [SEL_W-1:0] tw_clamp(input logic [SEL_W-1:0] s);
      return (s >= SEL_W'(STAGES)) ? SEL_W'(STAGES - 1) : s;
   endfunction

endpackage

// File: rtl/tw_skid_fifo.sv
// Two-entry FIFO holding {re, im, bfly} twiddles that arrive while the consumer stalls.
module tw_skid_fifo
   import fft_tw_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  tw_entry_t  i_data,
   output tw_entry_t  o_data,
   output logic       o_full,
   output logic       o_empty,
   output logic [1:0] o_count
);

   tw_entry_t  r_mem [2];
   logic       r_wrPtr;
   logic       r_rdPtr;
   logic [1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (i_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rdPtr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle ROM reader: per-stage address generation, ROM latency absorption, valid/ready stream.
// Define TWF_CONJ_EN to emit conjugate twiddles (negated imaginary part) for the forward FFT.
module twiddle_fetch_ctrl
   import fft_tw_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [SEL_W-1:0]  i_stage_sel,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_re,
   input  logic [DATA_W-1:0] i_rom_im,
   output logic              o_tw_valid,
   input  logic              i_tw_ready,
   output logic [DATA_W-1:0] o_tw_re,
   output logic [DATA_W-1:0] o_tw_im,
   output logic [BFLY_W-1:0] o_tw_bfly
);

   tw_state_t         r_state;
   logic [SEL_W-1:0]  r_stage;
   logic [BFLY_W-1:0] r_issueCnt;
   logic [BFLY_W-1:0] r_aBfly;
   logic [BFLY_W-1:0] r_bBfly;
   logic              r_addrVld;
   logic              r_romVld;
   logic [ADDR_W-1:0] r_romAddr;
   logic              r_busy;
   logic              r_done;
   logic              r_twValid;
   tw_entry_t         r_twOut;

   logic              w_pop;
   logic              w_outFree;
   logic              w_fifoPop;
   logic              w_fifoPush;
   logic              w_romToOut;
   logic              w_fifoFull;
   logic              w_fifoEmpty;
   logic              w_issue;
   logic [1:0]        w_fifoCount;
   logic [2:0]        w_inUse;
   logic [DATA_W-1:0] w_romIm;
   tw_entry_t         w_romEntry;
   tw_entry_t         w_fifoHead;

`ifdef TWF_CONJ_EN
   assign w_romIm = -i_rom_im;
`else
   assign w_romIm = i_rom_im;
`endif

   assign w_romEntry = '{re: i_rom_re, im: w_romIm, bfly: r_bBfly};

   // Older skid entries always reach the output register before fresh ROM data
   assign w_pop      = r_twValid && i_tw_ready;
   assign w_outFree  = !r_twValid || w_pop;
   assign w_fifoPop  = w_outFree && !w_fifoEmpty;
   assign w_romToOut = w_outFree && w_fifoEmpty && r_romVld;
   assign w_fifoPush = r_romVld && !w_romToOut && (!w_fifoFull || w_fifoPop);

   // Skid entries plus reads in flight stay below 2, plus one credit for the output slot
   assign w_inUse = 3'(r_twValid) + 3'(w_fifoCount) + 3'(r_addrVld) + 3'(r_romVld);
   assign w_issue = (r_state == ISSUE) && ((w_inUse - 3'(w_pop)) < TW_CREDITS);

   tw_skid_fifo u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_fifoPush),
      .i_pop   (w_fifoPop),
      .i_data  (w_romEntry),
      .o_data  (w_fifoHead),
      .o_full  (w_fifoFull),
      .o_empty (w_fifoEmpty),
      .o_count (w_fifoCount)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_stage    <= '0;
         r_issueCnt <= '0;
         r_aBfly    <= '0;
         r_bBfly    <= '0;
         r_addrVld  <= 1'b0;
         r_romVld   <= 1'b0;
         r_romAddr  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_twValid  <= 1'b0;
         r_twOut    <= '0;
      end else begin
         r_addrVld <= w_issue;
         r_romVld  <= r_addrVld;
         r_bBfly   <= r_aBfly;
         r_done    <= 1'b0;

         if (w_issue) begin
            r_romAddr  <= tw_base(r_stage) + ADDR_W'(r_issueCnt & tw_mask(r_stage));
            r_aBfly    <= r_issueCnt;
            r_issueCnt <= r_issueCnt + BFLY_W'(1);
         end

         if (w_fifoPop) begin
            r_twValid <= 1'b1;
            r_twOut   <= w_fifoHead;
         end else if (w_romToOut) begin
            r_twValid <= 1'b1;
            r_twOut   <= w_romEntry;
         end else if (w_pop) begin
            r_twValid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_stage    <= tw_clamp(i_stage_sel);
                  r_issueCnt <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (w_issue && (r_issueCnt == '1)) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_pop && (r_twOut.bfly == '1)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_rom_addr = r_romAddr;
   assign o_tw_valid = r_twValid;
   assign o_tw_re    = r_twOut.re;
   assign o_tw_im    = r_twOut.im;
   assign o_tw_bfly  = r_twOut.bfly;

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Randomized self-checking bench for twiddle_fetch_ctrl against a per-stage twiddle sequence model.
// Expected imaginary parts follow TWF_CONJ_EN when the bench is built with that macro.
module tb_twiddle_fetch_ctrl;
   import fft_tw_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [SEL_W-1:0]  stage_sel;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_re;
   logic [DATA_W-1:0] rom_im;
   logic              tw_valid;
   logic              tw_ready;
   logic [DATA_W-1:0] tw_re;
   logic [DATA_W-1:0] tw_im;
   logic [BFLY_W-1:0] tw_bfly;

   logic [DATA_W-1:0] romRe [32];
   logic [DATA_W-1:0] romIm [32];

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] hsRe [$];
   logic [DATA_W-1:0] hsIm [$];
   int                hsBfly [$];
   int                hsN [$];
   int                addrLog [$];
   int                doneCnt, doneN, stallViol, maxAhead, firstValidN;
   bit                finished;

   always #5 clk = ~clk;

   twiddle_fetch_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_stage_sel (stage_sel),
      .o_busy      (busy),
      .o_done      (done),
      .o_rom_addr  (rom_addr),
      .i_rom_re    (rom_re),
      .i_rom_im    (rom_im),
      .o_tw_valid  (tw_valid),
      .i_tw_ready  (tw_ready),
      .o_tw_re     (tw_re),
      .o_tw_im     (tw_im),
      .o_tw_bfly   (tw_bfly)
   );

   always @(posedge clk) begin
      rom_re <= romRe[rom_addr];
      rom_im <= romIm[rom_addr];
   end

   function automatic int refAddr(input int s, input int b);
      int e = (s >= STAGES) ? STAGES - 1 : s;
      return ((1 << e) - 1) + (b % (1 << e));
   endfunction

   function automatic logic [DATA_W-1:0] refIm(input int a);
      logic [DATA_W-1:0] v = romIm[a];
`ifdef TWF_CONJ_EN
      v = DATA_W'(0) - v;
`endif
      return v;
   endfunction

   task automatic startSeq(input int s);
      @(negedge clk);
      start     = 1'b1;
      stage_sel = SEL_W'(s);
      @(negedge clk);
      start     = 1'b0;
   endtask

   // mode 0: always ready, 1: ready on even cycles, 2: random ready
   task automatic collect(input int mode, input int budget, input int pulseAt);
      int                n = 0;
      int                issues = 0;
      int                prevAddr = int'(rom_addr);
      bit                stalled = 0;
      logic [DATA_W-1:0] pRe = '0, pIm = '0;
      logic [BFLY_W-1:0] pBfly = '0;
      hsRe.delete(); hsIm.delete(); hsBfly.delete(); hsN.delete(); addrLog.delete();
      doneCnt = 0; doneN = -1; stallViol = 0; maxAhead = 0; firstValidN = -1; finished = 0;
      while (n < budget && !finished) begin
         addrLog.push_back(int'(rom_addr));
         if (n > 0 && int'(rom_addr) != prevAddr) issues++;
         prevAddr = int'(rom_addr);
         if (issues - hsN.size() > maxAhead) maxAhead = issues - hsN.size();
         if (stalled && !(tw_valid && tw_re == pRe && tw_im == pIm && tw_bfly == pBfly)) stallViol++;
         if (tw_valid && firstValidN < 0) firstValidN = n;
         if (done) begin
            doneCnt++;
            if (doneN < 0) doneN = n;
         end
         if (doneN >= 0 && n >= doneN + 2) begin
            finished = 1;
         end else begin
            start = (n == pulseAt);
            if (n == pulseAt) stage_sel = 3'd1;
            tw_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
            if (tw_valid && tw_ready) begin
               hsRe.push_back(tw_re); hsIm.push_back(tw_im);
               hsBfly.push_back(int'(tw_bfly)); hsN.push_back(n);
            end
            stalled = tw_valid && !tw_ready;
            pRe = tw_re; pIm = tw_im; pBfly = tw_bfly;
            @(negedge clk);
            n++;
         end
      end
      start    = 1'b0;
      tw_ready = 1'b1;
   endtask

   task automatic test_reset();
      int doneSeen = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++; if (tw_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", tw_valid); end
      checks++; if (rom_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", rom_addr); end
      checks++; if ({tw_re, tw_im, tw_bfly} !== '0) begin errors++; $display("[TB] FAIL reset_data got %h/%h/%0d want 0", tw_re, tw_im, tw_bfly); end
      rst_n = 1'b1;
      startSeq(3);
      collect(0, 6, -1);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy got %b want 1", busy); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
      checks++; if (tw_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got %b want 0", tw_valid); end
      checks++; if (rom_addr !== '0) begin errors++; $display("[TB] FAIL abort_addr got %0d want 0", rom_addr); end
      for (int i = 0; i < 8; i++) begin
         if (done || busy) doneSeen++;
         @(negedge clk);
      end
      checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d cycles of done/busy want 0", doneSeen); end
   endtask

   task automatic test_stage2();
      startSeq(2);
      collect(0, 100, -1);
      checks++; if (!finished) begin errors++; $display("[TB] FAIL s2_finish got timeout want done"); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (i + 1 >= addrLog.size() || addrLog[i+1] != refAddr(2, i)) begin
            errors++; $display("[TB] FAIL s2_addr[%0d] got %0d want %0d", i, (i + 1 < addrLog.size()) ? addrLog[i+1] : -1, refAddr(2, i));
         end
      end
      checks++; if (firstValidN != 3) begin errors++; $display("[TB] FAIL s2_latency got %0d want 3", firstValidN); end
      checks++; if (hsN.size() != 16) begin errors++; $display("[TB] FAIL s2_count got %0d want 16", hsN.size()); end
      for (int i = 0; i < 16 && i < hsN.size(); i++) begin
         checks++;
         if (hsBfly[i] != i || hsRe[i] !== romRe[refAddr(2, i)] || hsIm[i] !== refIm(refAddr(2, i)) || hsN[i] != 3 + i) begin
            errors++; $display("[TB] FAIL s2_tw[%0d] got b=%0d %h/%h n=%0d want b=%0d %h/%h n=%0d", i, hsBfly[i], hsRe[i], hsIm[i], hsN[i], i, romRe[refAddr(2, i)], refIm(refAddr(2, i)), 3 + i);
         end
      end
      checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL s2_done_pulses got %0d want 1", doneCnt); end
      checks++;
      if (hsN.size() == 0 || doneN != hsN[hsN.size()-1] + 1) begin
         errors++; $display("[TB] FAIL s2_done_time got %0d want last handshake+1", doneN);
      end
   endtask

   task automatic test_stage4_rom();
      startSeq(4);
      collect(0, 100, -1);
      checks++;
      if (hsN.size() < 1 || hsRe[0] !== 16'h0100 || hsIm[0] !== 16'h0000 || hsBfly[0] != 0) begin
         errors++; $display("[TB] FAIL s4_first got %h/%h want 0100/0000", (hsRe.size() > 0) ? hsRe[0] : 16'hxxxx, (hsIm.size() > 0) ? hsIm[0] : 16'hxxxx);
      end
      checks++; if (hsN.size() != 16) begin errors++; $display("[TB] FAIL s4_count got %0d want 16", hsN.size()); end
      for (int i = 0; i < 16 && i < hsN.size(); i++) begin
         checks++;
         if (hsBfly[i] != i || hsRe[i] !== romRe[refAddr(4, i)] || hsIm[i] !== refIm(refAddr(4, i))) begin
            errors++; $display("[TB] FAIL s4_tw[%0d] got b=%0d %h/%h want b=%0d %h/%h", i, hsBfly[i], hsRe[i], hsIm[i], i, romRe[refAddr(4, i)], refIm(refAddr(4, i)));
         end
      end
   endtask

   task automatic test_backpressure();
      startSeq(3);
      collect(1, 200, -1);
      checks++; if (!finished) begin errors++; $display("[TB] FAIL bp_finish got timeout want done"); end
      checks++; if (hsN.size() != 16) begin errors++; $display("[TB] FAIL bp_count got %0d want 16", hsN.size()); end
      for (int i = 0; i < 16 && i < hsN.size(); i++) begin
         checks++;
         if (hsBfly[i] != i || hsRe[i] !== romRe[refAddr(3, i)] || hsIm[i] !== refIm(refAddr(3, i))) begin
            errors++; $display("[TB] FAIL bp_tw[%0d] got b=%0d %h/%h want b=%0d %h/%h", i, hsBfly[i], hsRe[i], hsIm[i], i, romRe[refAddr(3, i)], refIm(refAddr(3, i)));
         end
      end
      checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes while stalled want 0", stallViol); end
      checks++; if (maxAhead > 3) begin errors++; $display("[TB] FAIL bp_outstanding got %0d unconsumed reads want <=3", maxAhead); end
      checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL bp_done_pulses got %0d want 1", doneCnt); end
   endtask

   task automatic test_start_ignored();
      startSeq(3);
      collect(0, 100, 4);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (i + 1 >= addrLog.size() || addrLog[i+1] != 7 + (i % 8)) begin
            errors++; $display("[TB] FAIL ign_addr[%0d] got %0d want %0d", i, (i + 1 < addrLog.size()) ? addrLog[i+1] : -1, 7 + (i % 8));
         end
      end
      checks++; if (hsN.size() != 16) begin errors++; $display("[TB] FAIL ign_count got %0d want 16", hsN.size()); end
      checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL ign_done_pulses got %0d want 1", doneCnt); end
   endtask

   task automatic test_conj();
      logic [DATA_W-1:0] want;
`ifdef TWF_CONJ_EN
      want = 16'hFF4B;
`else
      want = 16'h00B5;
`endif
      startSeq(1);
      collect(0, 100, -1);
      checks++;
      if (hsN.size() < 1 || hsIm[0] !== want || hsRe[0] !== romRe[1]) begin
         errors++; $display("[TB] FAIL conj_im got %h want %h", (hsIm.size() > 0) ? hsIm[0] : 16'hxxxx, want);
      end
   endtask

   task automatic test_stage0_clamp();
      int stg [2] = '{0, 7};
      foreach (stg[k]) begin
         startSeq(stg[k]);
         collect(2, 300, -1);
         checks++; if (!finished || hsN.size() != 16) begin errors++; $display("[TB] FAIL rnd%0d_count got %0d want 16", stg[k], hsN.size()); end
         for (int i = 0; i < 16 && i < hsN.size(); i++) begin
            checks++;
            if (hsBfly[i] != i || hsRe[i] !== romRe[refAddr(stg[k], i)] || hsIm[i] !== refIm(refAddr(stg[k], i))) begin
               errors++; $display("[TB] FAIL rnd%0d_tw[%0d] got b=%0d %h/%h want b=%0d %h/%h", stg[k], i, hsBfly[i], hsRe[i], hsIm[i], i, romRe[refAddr(stg[k], i)], refIm(refAddr(stg[k], i)));
            end
         end
         checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL rnd%0d_stable got %0d want 0", stg[k], stallViol); end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      stage_sel = '0;
      tw_ready  = 1'b1;
      for (int a = 0; a < 32; a++) begin
         romRe[a] = DATA_W'($urandom);
         romIm[a] = DATA_W'($urandom);
      end
      romRe[15] = 16'h0100;
      romIm[15] = 16'h0000;
      romIm[1]  = 16'h00B5;
      test_reset();
      test_stage2();
      test_stage4_rom();
      test_backpressure();
      test_start_ignored();
      test_conj();
      test_stage0_clamp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got no completion want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
